// File: rtl/regfile_bank8_pkg.sv
// Shared constants and helpers for the 8-entry writeback register bank.
// Also used by the write-select decoder and the writeback stage.
package regfile_bank8_pkg;

    localparam int NUM_REGS      = 8;
    localparam int REG_ADDR_W    = 3;
    localparam int DEFAULT_WIDTH = 32;

    function automatic logic is_onehot8(input logic [7:0] sel);
        return (sel != 8'h00) && ((sel & (sel - 8'h01)) == 8'h00);
    endfunction

endpackage

// File: rtl/regfile_read_mux.sv
// One combinational read port: array select, same-cycle bypass, reg0 forcing.
module regfile_read_mux
    import regfile_bank8_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ZERO_REG0 = 1,
    parameter int BYPASS    = 1
) (
    input  logic [REG_ADDR_W-1:0]           addr,
    input  logic [NUM_REGS-1:0][WIDTH-1:0]  regs,
    input  logic [NUM_REGS-1:0]             byp_sel,
    input  logic [WIDTH-1:0]                byp_data,
    output logic [WIDTH-1:0]                data
);

    // byp_sel only carries committed writes, so illegal selects never reach here
    always_comb begin
        data = regs[addr];
        if (BYPASS != 0 && byp_sel[addr]) begin
            data = byp_data;
        end
        if (ZERO_REG0 != 0 && addr == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/regfile_bank8.sv
// 8-entry register bank fed by a one-hot write select, with two async
// read ports, write-to-read bypass, sticky illegal-select flag and write counter.
module regfile_bank8
    import regfile_bank8_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ZERO_REG0 = 1,
    parameter int BYPASS    = 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic [NUM_REGS-1:0]   write_sel,
    input  logic [WIDTH-1:0]      data_write,
    input  logic [REG_ADDR_W-1:0] read_addr_a,
    input  logic [REG_ADDR_W-1:0] read_addr_b,
    output logic [WIDTH-1:0]      data_read_a,
    output logic [WIDTH-1:0]      data_read_b,
    output logic                  write_sel_err,
    output logic [7:0]            write_count
);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic                           legal;
    logic                           illegal;
    logic                           discard;
    logic                           commit;
    logic [NUM_REGS-1:0]            commit_sel;

    // A write in flight while reset is held is dropped, including its bypass
    always_comb begin
        legal      = is_onehot8(write_sel);
        illegal    = (write_sel != '0) && !legal;
        discard    = (ZERO_REG0 != 0) && (write_sel == 8'h01);
        commit     = legal && !discard && !ctrl_reset;
        commit_sel = commit ? write_sel : '0;
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            regs          <= '0;
            write_sel_err <= 1'b0;
            write_count   <= 8'h00;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_sel[i]) begin
                    regs[i] <= data_write;
                end
            end
            if (commit) begin
                write_count <= write_count + 8'h01;
            end
            if (illegal) begin
                write_sel_err <= 1'b1;
            end
        end
    end

    regfile_read_mux #(
        .WIDTH     (WIDTH),
        .ZERO_REG0 (ZERO_REG0),
        .BYPASS    (BYPASS)
    ) u_read_a (
        .addr     (read_addr_a),
        .regs     (regs),
        .byp_sel  (commit_sel),
        .byp_data (data_write),
        .data     (data_read_a)
    );

    regfile_read_mux #(
        .WIDTH     (WIDTH),
        .ZERO_REG0 (ZERO_REG0),
        .BYPASS    (BYPASS)
    ) u_read_b (
        .addr     (read_addr_b),
        .regs     (regs),
        .byp_sel  (commit_sel),
        .byp_data (data_write),
        .data     (data_read_b)
    );

endmodule

// File: tb/tb_regfile_bank8.sv
// Self-checking bench for regfile_bank8: scenario tasks with a read scoreboard.
module tb_regfile_bank8;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b0;
    logic [7:0]  write_sel = 8'h00;
    logic [31:0] data_write = 32'h0;
    logic [2:0]  read_addr_a = 3'd0;
    logic [2:0]  read_addr_b = 3'd0;
    logic [31:0] data_read_a;
    logic [31:0] data_read_b;
    logic        write_sel_err;
    logic [7:0]  write_count;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [31:0] model_regs[8];

    regfile_bank8 #(
        .WIDTH     (32),
        .ZERO_REG0 (1),
        .BYPASS    (1)
    ) dut (
        .clock         (clock),
        .ctrl_reset    (ctrl_reset),
        .write_sel     (write_sel),
        .data_write    (data_write),
        .read_addr_a   (read_addr_a),
        .read_addr_b   (read_addr_b),
        .data_read_a   (data_read_a),
        .data_read_b   (data_read_b),
        .write_sel_err (write_sel_err),
        .write_count   (write_count)
    );

    always #5 clock = ~clock;

    task automatic test_reset;
        #1;
        ctrl_reset = 1'b1;
        read_addr_a = 3'd3;
        read_addr_b = 3'd7;
        #1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front();
        total++;
        if (data_read_a !== e) begin
            bad++;
            $display("FAIL reset_read_a got=%h exp=%h", data_read_a, e);
        end
        e = exp_q.pop_front();
        total++;
        if (data_read_b !== e) begin
            bad++;
            $display("FAIL reset_read_b got=%h exp=%h", data_read_b, e);
        end
        total++;
        if (write_sel_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err got=%b exp=0", write_sel_err);
        end
        total++;
        if (write_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_count got=%0d exp=0", write_count);
        end
        @(negedge clock);
        ctrl_reset = 1'b0;
    endtask

    task automatic test_legal_write;
        @(negedge clock);
        write_sel = 8'h08;
        data_write = 32'hDEADBEEF;
        read_addr_a = 3'd3;
        exp_q.push_back(32'hDEADBEEF);
        @(posedge clock);
        #1;
        write_sel = 8'h00;
        data_write = 32'h0;
        #1;
        e = exp_q.pop_front();
        total++;
        if (data_read_a !== e) begin
            bad++;
            $display("FAIL legal_read got=%h exp=%h", data_read_a, e);
        end
        total++;
        if (write_count !== 8'd1) begin
            bad++;
            $display("FAIL legal_count got=%0d exp=1", write_count);
        end
    endtask

    task automatic test_bypass;
        @(negedge clock);
        write_sel = 8'h20;
        data_write = 32'h12345678;
        read_addr_b = 3'd5;
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'h12345678);
        #1;
        e = exp_q.pop_front();
        total++;
        if (data_read_b !== e) begin
            bad++;
            $display("FAIL bypass_same got=%h exp=%h", data_read_b, e);
        end
        @(posedge clock);
        #1;
        write_sel = 8'h00;
        data_write = 32'h0;
        #1;
        e = exp_q.pop_front();
        total++;
        if (data_read_b !== e) begin
            bad++;
            $display("FAIL bypass_after got=%h exp=%h", data_read_b, e);
        end
        total++;
        if (write_count !== 8'd2) begin
            bad++;
            $display("FAIL bypass_count got=%0d exp=2", write_count);
        end
    endtask

    task automatic test_reg0;
        @(negedge clock);
        write_sel = 8'h01;
        data_write = 32'h1;
        read_addr_a = 3'd0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        total++;
        if (data_read_a !== e) begin
            bad++;
            $display("FAIL reg0_same got=%h exp=%h", data_read_a, e);
        end
        @(posedge clock);
        #1;
        write_sel = 8'h00;
        #1;
        e = exp_q.pop_front();
        total++;
        if (data_read_a !== e) begin
            bad++;
            $display("FAIL reg0_after got=%h exp=%h", data_read_a, e);
        end
        total++;
        if (write_count !== 8'd2) begin
            bad++;
            $display("FAIL reg0_count got=%0d exp=2", write_count);
        end
        total++;
        if (write_sel_err !== 1'b0) begin
            bad++;
            $display("FAIL reg0_err got=%b exp=0", write_sel_err);
        end
    endtask

    task automatic test_illegal;
        @(negedge clock);
        write_sel = 8'h04;
        data_write = 32'hA5A5A5A5;
        @(posedge clock);
        @(negedge clock);
        write_sel = 8'h06;
        data_write = 32'hFFFFFFFF;
        read_addr_a = 3'd2;
        read_addr_b = 3'd1;
        exp_q.push_back(32'hA5A5A5A5);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        total++;
        if (data_read_a !== e) begin
            bad++;
            $display("FAIL illegal_nobyp got=%h exp=%h", data_read_a, e);
        end
        e = exp_q.pop_front();
        total++;
        if (data_read_b !== e) begin
            bad++;
            $display("FAIL illegal_nobyp1 got=%h exp=%h", data_read_b, e);
        end
        @(posedge clock);
        #1;
        write_sel = 8'h00;
        data_write = 32'h0;
        #1;
        exp_q.push_back(32'hA5A5A5A5);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front();
        total++;
        if (data_read_a !== e) begin
            bad++;
            $display("FAIL illegal_reg2 got=%h exp=%h", data_read_a, e);
        end
        e = exp_q.pop_front();
        total++;
        if (data_read_b !== e) begin
            bad++;
            $display("FAIL illegal_reg1 got=%h exp=%h", data_read_b, e);
        end
        total++;
        if (write_count !== 8'd3) begin
            bad++;
            $display("FAIL illegal_count got=%0d exp=3", write_count);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            total++;
            if (write_sel_err !== 1'b1) begin
                bad++;
                $display("FAIL illegal_sticky%0d got=%b exp=1",
                         i, write_sel_err);
            end
        end
    endtask

    task automatic test_wrap_and_reset;
        int k;
        @(negedge clock);
        ctrl_reset = 1'b1;
        #1;
        ctrl_reset = 1'b0;
        total++;
        if (write_sel_err !== 1'b0) begin
            bad++;
            $display("FAIL wrap_err_clr got=%b exp=0", write_sel_err);
        end
        for (int r = 0; r < 8; r++) model_regs[r] = 32'h0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            k = 1 + (i % 7);
            write_sel = 8'h01 << k;
            data_write = 32'h1000 + i;
            model_regs[k] = 32'h1000 + i;
            @(posedge clock);
            #1;
            if (i == 254) begin
                total++;
                if (write_count !== 8'd255) begin
                    bad++;
                    $display("FAIL wrap_255 got=%0d exp=255", write_count);
                end
            end
        end
        write_sel = 8'h00;
        read_addr_a = 3'd4;
        read_addr_b = 3'd7;
        #1;
        total++;
        if (write_count !== 8'd0) begin
            bad++;
            $display("FAIL wrap_0 got=%0d exp=0", write_count);
        end
        exp_q.push_back(model_regs[4]);
        exp_q.push_back(model_regs[7]);
        e = exp_q.pop_front();
        total++;
        if (data_read_a !== e) begin
            bad++;
            $display("FAIL wrap_reg4 got=%h exp=%h", data_read_a, e);
        end
        e = exp_q.pop_front();
        total++;
        if (data_read_b !== e) begin
            bad++;
            $display("FAIL wrap_reg7 got=%h exp=%h", data_read_b, e);
        end
        @(negedge clock);
        write_sel = 8'h10;
        data_write = 32'hCAFEF00D;
        #2;
        ctrl_reset = 1'b1;
        #1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front();
        total++;
        if (data_read_a !== e) begin
            bad++;
            $display("FAIL rst_mid_a got=%h exp=%h", data_read_a, e);
        end
        e = exp_q.pop_front();
        total++;
        if (data_read_b !== e) begin
            bad++;
            $display("FAIL rst_mid_b got=%h exp=%h", data_read_b, e);
        end
        total++;
        if (write_count !== 8'd0 || write_sel_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_flags got=%0d/%b exp=0/0",
                     write_count, write_sel_err);
        end
        @(posedge clock);
        #1;
        @(negedge clock);
        ctrl_reset = 1'b0;
        write_sel = 8'h00;
        data_write = 32'h0;
        #1;
        exp_q.push_back(32'h0);
        e = exp_q.pop_front();
        total++;
        if (data_read_a !== e) begin
            bad++;
            $display("FAIL rst_lost_write got=%h exp=%h", data_read_a, e);
        end
        total++;
        if (write_count !== 8'd0) begin
            bad++;
            $display("FAIL rst_held_count got=%0d exp=0", write_count);
        end
    endtask

    initial begin
        test_reset();
        test_legal_write();
        test_bypass();
        test_reg0();
        test_illegal();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
